// File: rtl/sram_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter_pkg
// Shared definitions for the SRAM port arbiter: the arbiter state encoding,
// the bus read/write codes, the all-bytes enable mask and the word returned
// to the CPU when an access is aborted.
// ----------------------------------------------------------------------------
package sram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IM_ACC  = 2'd1,
      DM_ACC  = 2'd2,
      RECOVER = 2'd3
   } arb_state_e;

   localparam logic        RW_READ       = 1'b0;
   localparam logic        RW_WRITE      = 1'b1;
   localparam logic [3:0]  BE_ALL        = 4'hF;
   localparam logic [31:0] ABORT_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_port_arbiter_timeout_ctr.sv
// ----------------------------------------------------------------------------
// arb_timeout_ctr
// Counts the cycles an SRAM access has been outstanding. The arbiter holds
// clear while no access is in flight, so the count is zero in the first
// strobe cycle. hit is raised in the TIMEOUT-th cycle of the access, which is
// the last cycle the arbiter waits for the memory before giving up.
// TIMEOUT must be greater than 0.
//
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-low reset
//   clear   - reload the count with zero
//   enable  - count this cycle (an access is outstanding)
//   hit     - the wait budget is used up in this cycle
// ----------------------------------------------------------------------------
module arb_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clear,
   input  logic enable,
   output logic hit
);

   localparam int               CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign hit = enable && (count_q == LAST);

   // The count parks at its final value once hit is reached; the arbiter
   // leaves the access state on that cycle, which clears it again.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !hit) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
// Shares the single SRAM channel between the CPU instruction port (im_*) and
// data port (dm_*). One access is sequenced at a time: a grant in IDLE loads
// the bus registers and raises the strobe on the same edge, the access ends on
// mem_sram_done or on timeout, and a dead RECOVER cycle follows every access.
// DM normally wins, but after DM_BURST_MAX consecutive DM grants with IM
// waiting, IM is served next.
//
// Ports:
//   clk_in, rst_in          - clock, synchronous active-low reset
//   start                   - boot copy complete; grants are held off until 1
//   im_work, im_addr        - instruction fetch request
//   im_dataout, im_ready    - registered fetch data and its one-cycle pulse
//   dm_work, dm_we, be_in,
//   dm_addr, dm_datain      - data access request
//   dm_dataout, dm_ready    - registered read data and completion pulse
//   stall                   - CPU stall
//   mem_sram_*              - SRAM channel of the memory interface
//   timeout_err             - sticky flag, set when an access is aborted
// ----------------------------------------------------------------------------
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 22,
   parameter int DATA_W       = 32,
   parameter int DM_BURST_MAX = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start,
   input  logic              im_work,
   input  logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_dataout,
   output logic              im_ready,
   input  logic              dm_work,
   input  logic              dm_we,
   input  logic [3:0]        be_in,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_datain,
   output logic [DATA_W-1:0] dm_dataout,
   output logic              dm_ready,
   output logic              stall,
   output logic              mem_sram_cs,
   output logic              mem_sram_rw,
   output logic [ADDR_W-1:0] mem_sram_addr,
   output logic [3:0]        mem_sram_be,
   output logic [DATA_W-1:0] mem_sram_data_wr,
   input  logic [DATA_W-1:0] mem_sram_data_rd,
   input  logic              mem_sram_done,
   output logic              timeout_err
);

   localparam int                 BURST_W     = (DM_BURST_MAX > 0) ? $clog2(DM_BURST_MAX + 1) : 1;
   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(DM_BURST_MAX);
   localparam logic [DATA_W-1:0]  ABORT_WORD  = DATA_W'(ABORT_PATTERN);

   arb_state_e         state_q,       state_d;
   logic [BURST_W-1:0] burst_cnt_q,   burst_cnt_d;
   logic               cs_q,          cs_d;
   logic               rw_q,          rw_d;
   logic [ADDR_W-1:0]  addr_q,        addr_d;
   logic [3:0]         be_q,          be_d;
   logic [DATA_W-1:0]  data_wr_q,     data_wr_d;
   logic [DATA_W-1:0]  im_dataout_q,  im_dataout_d;
   logic [DATA_W-1:0]  dm_dataout_q,  dm_dataout_d;
   logic               im_ready_q,    im_ready_d;
   logic               dm_ready_q,    dm_ready_d;
   logic               timeout_err_q, timeout_err_d;

   logic in_acc;
   logic timer_hit;

   assign in_acc = (state_q == IM_ACC) || (state_q == DM_ACC);

   arb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .clear  (!in_acc),
      .enable (in_acc),
      .hit    (timer_hit)
   );

   assign mem_sram_cs      = cs_q;
   assign mem_sram_rw      = rw_q;
   assign mem_sram_addr    = addr_q;
   assign mem_sram_be      = be_q;
   assign mem_sram_data_wr = data_wr_q;
   assign im_dataout       = im_dataout_q;
   assign dm_dataout       = dm_dataout_q;
   assign im_ready         = im_ready_q;
   assign dm_ready         = dm_ready_q;
   assign timeout_err      = timeout_err_q;

   // A port stops stalling the CPU in the cycle its ready pulse is high.
   assign stall = !start || (im_work && !im_ready_q) || (dm_work && !dm_ready_q);

   // Arbitration, access sequencing and bus register loading. The bus fields
   // are loaded together with the strobe on the grant edge and held until the
   // access ends. A port that dropped its request during the access gets no
   // ready pulse and keeps its old data. A done pulse outside an access state
   // is ignored because only the access states look at it.
   always_comb begin
      state_d       = state_q;
      burst_cnt_d   = burst_cnt_q;
      cs_d          = cs_q;
      rw_d          = rw_q;
      addr_d        = addr_q;
      be_d          = be_q;
      data_wr_d     = data_wr_q;
      im_dataout_d  = im_dataout_q;
      dm_dataout_d  = dm_dataout_q;
      im_ready_d    = 1'b0;
      dm_ready_d    = 1'b0;
      timeout_err_d = timeout_err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (dm_work && (!im_work || (burst_cnt_q < BURST_LIMIT))) begin
                  state_d   = DM_ACC;
                  cs_d      = 1'b1;
                  rw_d      = dm_we;
                  addr_d    = dm_addr;
                  be_d      = (dm_we == RW_WRITE) ? be_in : BE_ALL;
                  data_wr_d = dm_datain;
                  if (!im_work) begin
                     burst_cnt_d = '0;
                  end else if (burst_cnt_q != BURST_LIMIT) begin
                     burst_cnt_d = burst_cnt_q + BURST_W'(1);
                  end
               end else if (im_work) begin
                  state_d     = IM_ACC;
                  cs_d        = 1'b1;
                  rw_d        = RW_READ;
                  addr_d      = im_addr;
                  be_d        = BE_ALL;
                  burst_cnt_d = '0;
               end
            end
         end

         IM_ACC, DM_ACC: begin
            if (mem_sram_done || timer_hit) begin
               state_d = RECOVER;
               cs_d    = 1'b0;
               if (!mem_sram_done) begin
                  timeout_err_d = 1'b1;
               end
               if (state_q == IM_ACC) begin
                  if (im_work) begin
                     im_ready_d   = 1'b1;
                     im_dataout_d = mem_sram_done ? mem_sram_data_rd : ABORT_WORD;
                  end
               end else if (dm_work) begin
                  dm_ready_d = 1'b1;
                  if (!mem_sram_done) begin
                     dm_dataout_d = ABORT_WORD;
                  end else if (rw_q == RW_READ) begin
                     dm_dataout_d = mem_sram_data_rd;
                  end
               end
            end
         end

         RECOVER: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and bus registers. Reset clears everything at once, so an access
   // in flight loses its strobe on that edge and is never replayed.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q       <= IDLE;
         burst_cnt_q   <= '0;
         cs_q          <= 1'b0;
         rw_q          <= 1'b0;
         addr_q        <= '0;
         be_q          <= '0;
         data_wr_q     <= '0;
         im_dataout_q  <= '0;
         dm_dataout_q  <= '0;
         im_ready_q    <= 1'b0;
         dm_ready_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         burst_cnt_q   <= burst_cnt_d;
         cs_q          <= cs_d;
         rw_q          <= rw_d;
         addr_q        <= addr_d;
         be_q          <= be_d;
         data_wr_q     <= data_wr_d;
         im_dataout_q  <= im_dataout_d;
         dm_dataout_q  <= dm_dataout_d;
         im_ready_q    <= im_ready_d;
         dm_ready_q    <= dm_ready_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule
